// File: rtl/sw_job_sequencer.sv
// Job sequencer for the Smith-Waterman engine: optional set-t phase, then NUM_JOBS scoring jobs in order.
// Latency: start pulse 2 cycles after i_go with skip_t; result read data 1 cycle after address.
// Backpressure: waits on engine busy/valid handshakes; per-wait watchdog aborts to TOUT on a hung engine.
module sw_job_sequencer #(
  parameter int NUM_JOBS    = 2,
  parameter int PARAM_W     = 16,
  parameter int RESULT_W    = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int GUARD_CYC   = 2,
  parameter int IDX_W       = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_go,
  input  logic                i_skip_t,
  input  logic                i_param_we,
  input  logic [IDX_W-1:0]    i_param_waddr,
  input  logic [PARAM_W-1:0]  i_param_wdata,
  input  logic [IDX_W-1:0]    i_res_raddr,
  output logic [RESULT_W-1:0] o_res_rdata,
  output logic                o_set_t,
  output logic                o_start_cal,
  output logic [PARAM_W-1:0]  o_param,
  input  logic                i_busy,
  input  logic                i_valid,
  input  logic [RESULT_W-1:0] i_result,
  output logic                o_running,
  output logic [IDX_W-1:0]    o_job_idx,
  output logic                o_done,
  output logic                o_timeout,
  output logic [IDX_W-1:0]    o_err_job
);

  typedef enum logic [3:0] {
    S_IDLE, S_SET_T, S_WAIT_T, S_LOAD, S_START,
    S_WAIT_V, S_WAIT_B, S_NEXT, S_DONE, S_TOUT
  } state_t;

  localparam logic [IDX_W:0]   NJ      = (IDX_W + 1)'(NUM_JOBS);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_JOBS - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  GUARD   = TO_W'(GUARD_CYC);

  state_t state, state_n;
  logic [IDX_W-1:0] job_idx;
  logic [TO_W-1:0]  wd_cnt;
  logic [PARAM_W-1:0]  param_tbl [NUM_JOBS];
  logic [RESULT_W-1:0] res_buf   [NUM_JOBS];

  logic idle_like, in_wait, guard_open, tout_hit, capture, go_acc, enter_load;
  logic [IDX_W-1:0] load_idx;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_TOUT);
  assign in_wait    = (state == S_WAIT_T) || (state == S_WAIT_V) || (state == S_WAIT_B);
  assign guard_open = (wd_cnt >= GUARD);
  assign tout_hit   = (wd_cnt == TO_LAST);
  assign go_acc     = idle_like && i_go;
  assign enter_load = (state_n == S_LOAD) && (state != S_LOAD);
  // The job about to be loaded: next index out of NEXT, job 0 out of a fresh start.
  assign load_idx   = (state == S_NEXT) ? job_idx + 1'b1 : (idle_like ? '0 : job_idx);
  assign o_running  = !idle_like;
  assign o_job_idx  = job_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode and the single-cycle engine pulses; progress wins over a same-cycle timeout.
  always_comb begin
    state_n     = state;
    o_set_t     = 1'b0;
    o_start_cal = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_TOUT: if (i_go) state_n = i_skip_t ? S_LOAD : S_SET_T;
      S_SET_T: begin
        o_set_t = 1'b1;
        state_n = S_WAIT_T;
      end
      S_WAIT_T: begin
        if (guard_open && !i_busy) state_n = S_LOAD;
        else if (tout_hit)         state_n = S_TOUT;
      end
      S_LOAD: state_n = S_START;
      S_START: begin
        o_start_cal = 1'b1;
        state_n     = S_WAIT_V;
      end
      S_WAIT_V: begin
        if (i_valid) begin
          capture = 1'b1;
          state_n = i_busy ? S_WAIT_B : S_NEXT;
        end else if (tout_hit) begin
          state_n = S_TOUT;
        end
      end
      S_WAIT_B: begin
        if (guard_open && !i_busy) state_n = S_NEXT;
        else if (tout_hit)         state_n = S_TOUT;
      end
      S_NEXT:  state_n = (job_idx == LAST) ? S_DONE : S_LOAD;
      default: state_n = S_IDLE;
    endcase
  end

  // Job index, parameter latch, watchdog and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_idx   <= '0;
      wd_cnt    <= '0;
      o_param   <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_err_job <= '0;
    end else begin
      if (go_acc) begin
        job_idx   <= '0;
        o_done    <= 1'b0;
        o_timeout <= 1'b0;
        o_err_job <= '0;
      end else if (state == S_NEXT && state_n == S_LOAD) begin
        job_idx <= job_idx + 1'b1;
      end
      // Latched on entry to LOAD so the word is stable a full cycle before the start pulse.
      if (enter_load) o_param <= param_tbl[load_idx];
      if (state_n != state) wd_cnt <= '0;
      else if (in_wait)     wd_cnt <= wd_cnt + 1'b1;
      if (state == S_NEXT && state_n == S_DONE) o_done <= 1'b1;
      if (in_wait && state_n == S_TOUT) begin
        o_timeout <= 1'b1;
        o_err_job <= job_idx;
      end
    end
  end

  // Parameter table: host writes only while no run is active, in-range addresses only.
  always_ff @(posedge clk) begin
    if (i_param_we && idle_like && ({1'b0, i_param_waddr} < NJ))
      param_tbl[i_param_waddr] <= i_param_wdata;
  end

  // Result buffer: first valid of each job is captured while waiting for it.
  always_ff @(posedge clk) begin
    if (capture) res_buf[job_idx] <= i_result;
  end

  // Registered result read port; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst)                              o_res_rdata <= '0;
    else if ({1'b0, i_res_raddr} < NJ)    o_res_rdata <= res_buf[i_res_raddr];
    else                                  o_res_rdata <= '0;
  end

endmodule
